// File: rtl/quickq_pkg.sv
// Shared QuickQ definitions used by the node store and the node control FSM.
package quickq_pkg;

   typedef enum logic [2:0] {
      MODE_FILL     = 3'b000,
      MODE_CNT_INC  = 3'b001,
      MODE_LOCATE   = 3'b010,
      MODE_FILL_DEQ = 3'b011,
      MODE_CNT_DEC  = 3'b100,
      MODE_IDLE     = 3'b101
   } mode_t;

   typedef enum logic [1:0] {
      SEL_DIN   = 2'b00,
      SEL_ROUTE = 2'b01,
      SEL_ONES  = 2'b10,
      SEL_HOLD  = 2'b11
   } mux_sel_t;

   typedef enum logic [2:0] {
      SW_INIT,
      SW_IDLE,
      SW_CAP,
      SW_COMMIT,
      SW_HOLD
   } swap_state_t;

   // Empty slots hold all-ones so they sort after every real key.
   localparam logic        EMPTY_KEY_BIT = 1'b1;
   localparam logic [31:0] EMPTY_KEY     = 32'hFFFF_FFFF;

endpackage

// File: rtl/quickq_node_mem.sv
// Node key array: one registered read port, one write port, two combinational peeks.
// With QUICKQ_INIT_SWEEP_EN the array has no reset and a sweep counter clears it after rst.
module quickq_node_mem
   import quickq_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DW    = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
`ifdef QUICKQ_INIT_SWEEP_EN
   input  logic          sweep,
   output logic          sweep_last,
`endif
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_q,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] cap_addr,
   output logic [DW-1:0] cap_data,
   input  logic [AW-1:0] loc_addr,
   output logic [DW-1:0] loc_data
);

   localparam logic [DW-1:0] KEY_EMPTY = {DW{EMPTY_KEY_BIT}};

   logic [DW-1:0] mem [DEPTH];
   logic          we_eff;
   logic [AW-1:0] wa;
   logic [DW-1:0] wd;

`ifdef QUICKQ_INIT_SWEEP_EN
   logic [AW-1:0] sweep_idx;

   always_ff @(posedge clk) begin
      if (rst)
         sweep_idx <= '0;
      else if (sweep)
         sweep_idx <= sweep_idx + 1'b1;
   end

   assign sweep_last = sweep && (sweep_idx == AW'(DEPTH - 1));

   always_comb begin
      we_eff = (sweep || wr_en) && !rst;
      wa     = sweep ? sweep_idx : wr_addr;
      wd     = sweep ? KEY_EMPTY : wr_data;
   end

   always_ff @(posedge clk) begin
      if (we_eff)
         mem[wa] <= wd;
   end
`else
   always_comb begin
      we_eff = wr_en && !rst;
      wa     = wr_addr;
      wd     = wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= KEY_EMPTY;
      end else if (we_eff) begin
         mem[wa] <= wd;
      end
   end
`endif

   // Write-first: a committed swap shows on rd_q in the very next cycle.
   always_ff @(posedge clk) begin
      if (rst)
         rd_q <= KEY_EMPTY;
      else if (we_eff && (wa == rd_addr))
         rd_q <= wd;
      else
         rd_q <= mem[rd_addr];
   end

   assign cap_data = mem[cap_addr];
   assign loc_data = mem[loc_addr];

endmodule

// File: rtl/quickq_node_store.sv
// QuickQ node storage responder: key array, temp register, occupancy count, compare/swap.
// Optional build macro: QUICKQ_INIT_SWEEP_EN (clear the array by a post-reset sweep).
module quickq_node_store
   import quickq_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          re,
   input  logic          we,
   input  logic [31:0]   rd_addr,
   input  logic [31:0]   wr_addr,
   input  logic [2:0]    mode,
   input  logic [1:0]    mux1_sel,
   input  logic [DW-1:0] din,
   input  logic [DW-1:0] route_data,
   output logic          result,
   output logic          swap_done,
   output logic          full,
   output logic          empty,
   output logic [31:0]   last_addr,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   output logic          ready
);

   localparam int            AW        = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
   localparam logic [DW-1:0] KEY_EMPTY = {DW{EMPTY_KEY_BIT}};
`ifdef QUICKQ_INIT_SWEEP_EN
   localparam swap_state_t   RST_STATE = SW_INIT;
`else
   localparam swap_state_t   RST_STATE = SW_IDLE;
`endif

   swap_state_t   state, state_n;
   logic [2:0]    mode_q;
   logic [DW-1:0] temp_q, old_q, rd_q, cap_data, loc_data, fill_data;
   logic [AW:0]   count, cnt_m1;
   logic          entry, fill_en, commit, sweep_last;
   logic          unused_bits;

   assign unused_bits = ^{re, rd_addr[31:AW], wr_addr[31:AW]};

   quickq_node_mem #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_mem (
      .clk      (clk),
      .rst      (rst),
`ifdef QUICKQ_INIT_SWEEP_EN
      .sweep    (state == SW_INIT),
      .sweep_last(sweep_last),
`endif
      .rd_addr  (rd_addr[AW-1:0]),
      .rd_q     (rd_q),
      .wr_en    (commit),
      .wr_addr  (wr_addr[AW-1:0]),
      .wr_data  (temp_q),
      .cap_addr (wr_addr[AW-1:0]),
      .cap_data (cap_data),
      .loc_addr (cnt_m1[AW-1:0]),
      .loc_data (loc_data)
   );

`ifndef QUICKQ_INIT_SWEEP_EN
   assign sweep_last = 1'b0;
`endif

   assign ready     = (state != SW_INIT);
   assign entry     = ready && (mode != mode_q);
   assign result    = temp_q < rd_q;
   assign full      = (count == CNT_FULL);
   assign empty     = (count == '0);
   assign cnt_m1    = count - 1'b1;
   assign last_addr = empty ? 32'd0 : {{(32 - AW - 1){1'b0}}, cnt_m1};

   // The swap owns temp_q while it is capturing or committing.
   assign fill_en = ready && (mode == MODE_FILL || mode == MODE_FILL_DEQ)
                    && (state != SW_CAP) && (state != SW_COMMIT);

   always_comb begin
      fill_data = temp_q;
      case (mux_sel_t'(mux1_sel))
         SEL_DIN:   fill_data = din;
         SEL_ROUTE: fill_data = route_data;
         SEL_ONES:  fill_data = KEY_EMPTY;
         default:   fill_data = temp_q;
      endcase
   end

   always_comb begin
      state_n   = state;
      swap_done = 1'b0;
      commit    = 1'b0;
      case (state)
         SW_INIT:   if (sweep_last) state_n = SW_IDLE;
         SW_IDLE:   if (we) state_n = SW_CAP;
         SW_CAP:    state_n = SW_COMMIT;
         SW_COMMIT: begin
            commit    = 1'b1;
            swap_done = 1'b1;
            state_n   = SW_HOLD;
         end
         SW_HOLD:   if (!we) state_n = SW_IDLE;
         default:   state_n = SW_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= RST_STATE;
      else
         state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q     <= MODE_IDLE;
         count      <= '0;
         temp_q     <= KEY_EMPTY;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         mode_q     <= mode;
         dout_valid <= 1'b0;
         if (commit)
            temp_q <= old_q;
         else if (fill_en)
            temp_q <= fill_data;
         if (entry && mode == MODE_CNT_INC && !full)
            count <= count + 1'b1;
         else if (entry && mode == MODE_CNT_DEC && !empty)
            count <= count - 1'b1;
         if (entry && mode == MODE_LOCATE && !empty) begin
            dout       <= loc_data;
            dout_valid <= 1'b1;
         end
      end
   end

   // Displaced key; only meaningful between CAP and COMMIT, so it needs no reset.
   always_ff @(posedge clk) begin
      if (state == SW_CAP)
         old_q <= cap_data;
   end

endmodule
